pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MDU_CYCLES, default 32: number of EX cycles a mult/div occupies the multiply/divide unit (legal range 2..63).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port id_rs, input, 5: rs field of the instruction in ID.
REQ-005 SHALL have port id_rt, input, 5: rt field of the instruction in ID.
REQ-006 SHALL have port id_uses_rt, input, 1: ID instruction reads rt as a source.
REQ-007 SHALL have port ex_memread, input, 1: instruction in EX is a load.
REQ-008 SHALL have port ex_rd, input, 5: destination register of the instruction in EX.
REQ-009 SHALL have port id_redirect, input, 1: branch taken or jump resolved in ID this cycle.
REQ-010 SHALL have port id_mdu_use, input, 1: ID instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-011 SHALL have port mdu_start, input, 1: a mult/div is issuing from ID to EX this cycle.
REQ-012 SHALL have port pc_wr, output, 1: PC write enable.
REQ-013 SHALL have port ifid_wr, output, 1: IF/ID register write enable (drives IRWr).
REQ-014 SHALL have port ifid_flush, output, 1: load NOP into IF/ID (drives Flush; effective only with ifid_wr=1).
REQ-015 SHALL have port idex_bubble, output, 1: insert bubble into ID/EX.
REQ-016 SHALL have port mdu_busy, output, 1: MDU occupied.
REQ-017 SHALL have port mdu_err, output, 1: sticky; mdu_start seen while busy.
REQ-018 SHALL have port stall_cnt, output, 16: saturating count of stall cycles.

Function
REQ-019 SHALL compute lu_haz = ex_memread & (ex_rd != 0) & ((ex_rd == id_rs) | (id_uses_rt & ex_rd == id_rt)), combinationally.
REQ-020 SHALL compute mdu_haz = id_mdu_use & mdu_busy, combinationally.
REQ-021 SHALL define stall = (lu_haz | mdu_haz) & ~rst.
REQ-022 SHALL drive, when stall=1: pc_wr=0, ifid_wr=0, ifid_flush=0, idex_bubble=1.
REQ-023 SHALL drive, when stall=0 and id_redirect=1: pc_wr=1, ifid_wr=1, ifid_flush=1, idex_bubble=0 (single-cycle flush, zero extra latency).
REQ-024 SHALL drive, when stall=0 and id_redirect=0: pc_wr=1, ifid_wr=1, ifid_flush=0, idex_bubble=0.
REQ-025 SHALL give stall priority over id_redirect, since the branch operands are not yet valid during a stall.
REQ-026 SHALL implement a 2-state FSM: IDLE (mdu_busy=0) and BUSY (mdu_busy=1), with a 6-bit down-counter cnt.
REQ-027 SHALL, in IDLE, when mdu_start=1 and stall=0: load cnt=MDU_CYCLES-1 and move to BUSY on the next edge; mdu_start with stall=1 SHALL be ignored.
REQ-028 SHALL, in BUSY, decrement cnt each cycle and return to IDLE on the edge where cnt==1.
- Result: mdu_busy is high for exactly MDU_CYCLES-1 cycles after the start cycle.
REQ-029 SHALL, in BUSY, ignore mdu_start (counter unaffected) and set mdu_err=1 until reset.
REQ-030 SHALL increment stall_cnt on every cycle with stall=1, saturating at 16'hFFFF (no wrap).
REQ-031 SHALL accept simultaneous lu_haz and mdu_haz as a single stall cycle, counted once.

Reset
REQ-032 SHALL, while rst=1, drive pc_wr=0, ifid_wr=0, ifid_flush=0, idex_bubble=0.
REQ-033 SHALL, on an edge with rst=1, set state=IDLE, cnt=0, mdu_busy=0, mdu_err=0, stall_cnt=0, including when asserted mid-MDU operation.
REQ-034 SHALL drive outputs per REQ-024 in the first cycle after rst deasserts if no hazard is present.

Verification
REQ-035 SHALL cover load-use: ex_memread=1, ex_rd=5, id_rs=5 for 1 cycle -> pc_wr=0, ifid_wr=0, idex_bubble=1, stall_cnt 0->1; next cycle with ex_memread=0 -> normal operation.
REQ-036 SHALL cover the $zero exemption: ex_memread=1, ex_rd=0, id_rs=0 -> no stall; also ex_rd=7, id_rt=7, id_uses_rt=0 -> no stall.
REQ-037 SHALL cover MDU occupancy: MDU_CYCLES=4, mdu_start pulse -> mdu_busy=1 for 3 cycles; id_mdu_use=1 held -> stall for those 3 cycles, stall_cnt=3.
REQ-038 SHALL cover redirect versus stall: id_redirect=1 with lu_haz=1 -> ifid_flush=0, stall; next cycle id_redirect=1 alone -> ifid_flush=1, ifid_wr=1, pc_wr=1.
REQ-039 SHALL cover the error flag and reset: mdu_start during BUSY -> mdu_err=1 and cnt sequence unchanged; rst for 1 cycle mid-BUSY -> mdu_busy=0, mdu_err=0, stall_cnt=0 next cycle.
REQ-040 SHALL cover saturation: force 65540 stall cycles -> stall_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Purpose : hazard control for a 5-stage pipeline (load-use, MDU occupancy, ID redirect flush).
// Latency : pipeline controls are combinational in the same cycle; MDU status and stall count are registered (1 cycle).
// Backpr. : a stall freezes PC and IF/ID and bubbles ID/EX; a stall outranks an ID redirect.
//
// Ports
//   clk, rst         : single clock, synchronous active-high reset
//   id_rs, id_rt     : source register fields of the instruction in ID
//   id_uses_rt       : the ID instruction actually reads rt
//   ex_memread/ex_rd : the EX instruction is a load, and its destination register
//   id_redirect      : branch taken / jump resolved in ID this cycle
//   id_mdu_use       : the ID instruction needs the multiply/divide unit or HI/LO
//   mdu_start        : a mult/div issues from ID to EX this cycle
//   pc_wr, ifid_wr   : PC and IF/ID write enables
//   ifid_flush       : load a NOP into IF/ID (only takes effect with ifid_wr)
//   idex_bubble      : insert a bubble into ID/EX
//   mdu_busy         : the MDU is occupied
//   mdu_err          : sticky, a mult/div was started while the MDU was busy
//   stall_cnt        : saturating count of stall cycles

module pipe_hazard_ctrl #(
    parameter int MDU_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    input  logic        id_redirect,
    input  logic        id_mdu_use,
    input  logic        mdu_start,
    output logic        pc_wr,
    output logic        ifid_wr,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        mdu_busy,
    output logic        mdu_err,
    output logic [15:0] stall_cnt
);

    // Counter reload value. The start cycle itself is not a busy cycle, so
    // the unit stays busy for MDU_CYCLES-1 cycles after it.
    localparam logic [5:0] CNT_INIT = 6'(MDU_CYCLES - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } mdu_state_e;

    mdu_state_e  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic lu_haz;
    logic mdu_haz;
    logic stall;
    logic rs_match;
    logic rt_match;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    // A load into $zero never creates a dependency: $zero always reads 0.
    always_comb begin
        rs_match = (ex_rd == id_rs);
        rt_match = id_uses_rt && (ex_rd == id_rt);
        lu_haz   = ex_memread && (ex_rd != 5'd0) && (rs_match || rt_match);
        mdu_haz  = id_mdu_use && (state_q == S_BUSY);
        // Both hazards together still make exactly one stall cycle.
        stall    = (lu_haz || mdu_haz) && !rst;
    end

    // ------------------------------------------------------------------
    // Pipeline register controls
    // ------------------------------------------------------------------
    // Priority: reset, then stall, then redirect. A redirect during a stall
    // is dropped because the branch operands in ID are not yet valid; the
    // branch re-evaluates once the stall clears.
    always_comb begin
        pc_wr       = 1'b0;
        ifid_wr     = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (rst) begin
            pc_wr       = 1'b0;
            ifid_wr     = 1'b0;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
        end else if (stall) begin
            pc_wr       = 1'b0;
            ifid_wr     = 1'b0;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b1;
        end else begin
            pc_wr       = 1'b1;
            ifid_wr     = 1'b1;
            ifid_flush  = id_redirect;
            idex_bubble = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // MDU occupancy FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // MDU occupancy FSM: next state
    // ------------------------------------------------------------------
    // A start that coincides with a stall is not really issuing (ID is
    // frozen), so it must not occupy the unit. A start while busy leaves
    // the countdown alone; it is only flagged.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (mdu_start && !stall) begin
                    state_d = S_BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 6'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // MDU occupancy FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        mdu_busy = (state_q == S_BUSY);
    end

    // ------------------------------------------------------------------
    // Sticky error flag and stall counter
    // ------------------------------------------------------------------
    always_comb begin
        err_d = err_q || (mdu_start && (state_q == S_BUSY));
        // Saturate rather than wrap so a long stall never reads as a short one.
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q       <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign mdu_err   = err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Purpose : self-checking bench for pipe_hazard_ctrl with a scoreboard and reference model.
// Latency : expectations are queued per driven cycle and popped by the monitor on the falling edge.
// Backpr. : none; the monitor drains one entry per cycle.

module tb_pipe_hazard_ctrl;

    localparam int MDU = 4;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        id_uses_rt, ex_memread, id_redirect, id_mdu_use, mdu_start;
    logic        pc_wr, ifid_wr, ifid_flush, idex_bubble, mdu_busy, mdu_err;
    logic [15:0] stall_cnt;

    pipe_hazard_ctrl #(.MDU_CYCLES(MDU)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_memread  (ex_memread),
        .ex_rd       (ex_rd),
        .id_redirect (id_redirect),
        .id_mdu_use  (id_mdu_use),
        .mdu_start   (mdu_start),
        .pc_wr       (pc_wr),
        .ifid_wr     (ifid_wr),
        .ifid_flush  (ifid_flush),
        .idex_bubble (idex_bubble),
        .mdu_busy    (mdu_busy),
        .mdu_err     (mdu_err),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        pc_wr;
        logic        ifid_wr;
        logic        ifid_flush;
        logic        idex_bubble;
        logic        mdu_busy;
        logic        mdu_err;
        logic [15:0] stall_cnt;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   stim_done = 1'b0;

    // Reference model state, in plain terms: how many busy cycles remain,
    // whether an overlapping start was ever seen, and how many stalls occurred.
    int   m_busy_left = 0;
    bit   m_err = 1'b0;
    int   m_stalls = 0;

    task automatic chk(input string name, input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%s]: got %0h expected %0h at %0t", name, tag, act, exp, $time);
        end
    endtask

    // Monitor: one expectation per driven cycle, compared away from the edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pc_wr",       e.tag, {15'd0, pc_wr},       {15'd0, e.pc_wr});
            chk("ifid_wr",     e.tag, {15'd0, ifid_wr},     {15'd0, e.ifid_wr});
            chk("ifid_flush",  e.tag, {15'd0, ifid_flush},  {15'd0, e.ifid_flush});
            chk("idex_bubble", e.tag, {15'd0, idex_bubble}, {15'd0, e.idex_bubble});
            chk("mdu_busy",    e.tag, {15'd0, mdu_busy},    {15'd0, e.mdu_busy});
            chk("mdu_err",     e.tag, {15'd0, mdu_err},     {15'd0, e.mdu_err});
            chk("stall_cnt",   e.tag, stall_cnt,            e.stall_cnt);
        end
    end

    // Drive one cycle: apply inputs, queue the expected response, advance the model.
    task automatic cyc(input string tag, input bit r, input bit mr, input int erd,
                       input int rs, input int rt, input bit urt, input bit redir,
                       input bit muse, input bit mst);
        exp_t e;
        bit   lu, mh, st;
        rst = r; ex_memread = mr; ex_rd = 5'(erd); id_rs = 5'(rs); id_rt = 5'(rt);
        id_uses_rt = urt; id_redirect = redir; id_mdu_use = muse; mdu_start = mst;

        lu = mr && (erd != 0) && ((erd == rs) || (urt && (erd == rt)));
        mh = muse && (m_busy_left > 0);
        st = (lu || mh) && !r;
        e.tag         = tag;
        e.pc_wr       = !r && !st;
        e.ifid_wr     = !r && !st;
        e.ifid_flush  = !r && !st && redir;
        e.idex_bubble = st;
        e.mdu_busy    = (m_busy_left > 0);
        e.mdu_err     = m_err;
        e.stall_cnt   = 16'(m_stalls);
        exp_q.push_back(e);

        @(posedge clk);
        if (r) begin
            m_busy_left = 0;
            m_err       = 1'b0;
            m_stalls    = 0;
        end else begin
            if (m_busy_left > 0) begin
                m_busy_left--;
                if (mst) m_err = 1'b1;
            end else if (mst && !st) begin
                m_busy_left = MDU - 1;
            end
            if (st && m_stalls < 65535) m_stalls++;
        end
        #1;
    endtask

    task automatic idle(input string tag);
        cyc(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        // Establish reset before any checking: registers are unknown until the first edge.
        rst = 1'b1; ex_memread = 0; ex_rd = 0; id_rs = 0; id_rt = 0;
        id_uses_rt = 0; id_redirect = 0; id_mdu_use = 0; mdu_start = 0;
        @(posedge clk);
        #1;

        // Reset held: all controls low, status cleared.
        cyc("reset", 1, 1, 5, 5, 0, 0, 1, 0, 1);
        idle("post_reset");

        // Load-use on rs, then release.
        cyc("lu_rs", 0, 1, 5, 5, 0, 0, 0, 0, 0);
        idle("lu_release");
        // Load-use through rt, only when rt is a source.
        cyc("lu_rt", 0, 1, 9, 1, 9, 1, 0, 0, 0);
        // $zero exemption and unused rt.
        cyc("zero_rd", 0, 1, 0, 0, 0, 1, 0, 0, 0);
        cyc("rt_unused", 0, 1, 7, 3, 7, 0, 0, 0, 0);

        // Redirect versus stall, then redirect alone.
        cyc("redir_stall", 0, 1, 5, 5, 0, 0, 1, 0, 0);
        cyc("redir_alone", 0, 0, 5, 5, 0, 0, 1, 0, 0);

        // MDU occupancy: start pulse, then ID holds an MDU user.
        cyc("mdu_start", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < MDU + 1; i++) cyc("mdu_use", 0, 0, 0, 0, 0, 0, 0, 1, 0);

        // Start during a stall is ignored.
        cyc("start_stalled", 0, 1, 3, 3, 0, 0, 0, 0, 1);
        idle("after_ignored");

        // Overlapping start sets the sticky error, countdown unchanged.
        cyc("mdu_start2", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc("start_busy", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle("busy_cont");
        // Both hazards at once on the last busy cycle: one stall.
        cyc("both_haz", 0, 1, 2, 2, 0, 0, 0, 1, 0);
        idle("err_sticky");
        // Reset mid-busy.
        cyc("mdu_start3", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc("rst_mid", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle("after_rst");

        // Randomized traffic with small register fields so hazards are frequent.
        for (int i = 0; i < 1500; i++) begin
            cyc("rand", ($urandom_range(0, 63) == 0), $urandom_range(0, 1),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 1), $urandom_range(0, 1),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
        end

        // Saturation: 65540 consecutive stalls from a clean start.
        cyc("sat_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 65540; i++) cyc("sat", 0, 1, 5, 5, 0, 0, 0, 0, 0);
        idle("sat_hold");
        idle("sat_hold2");

        stim_done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
